// File: rtl/md_scheduler.sv
// md_scheduler: HI/LO owner and sequencer for multi-cycle mult/div ops,
// plus the D-stage stall request for MD-class instructions.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_Instr,
  input  logic [31:0] E_RD1_forward,
  input  logic [31:0] E_RD2_forward,
  input  logic [31:0] D_Instr,
  output logic        Start,
  output logic        Busy,
  output logic        MD_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDout
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [WORD_W-1:0]     hi_q, lo_q;
  logic [2*WORD_W-1:0]   pend_q;
  logic                  pend_ok_q;

  // Decode of E and D stage instructions
  logic        e_special, d_special;
  logic [5:0]  e_func, d_func;
  logic        e_muldiv, e_is_mult, e_mthi, e_mtlo, e_mfhi, e_mflo, d_md;

  assign e_special = (E_Instr[31:26] == 6'b000000);
  assign d_special = (D_Instr[31:26] == 6'b000000);
  assign e_func    = E_Instr[5:0];
  assign d_func    = D_Instr[5:0];
  assign e_muldiv  = e_special && (e_func inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign e_is_mult = e_special && (e_func inside {F_MULT, F_MULTU});
  assign e_mthi    = e_special && (e_func == F_MTHI);
  assign e_mtlo    = e_special && (e_func == F_MTLO);
  assign e_mfhi    = e_special && (e_func == F_MFHI);
  assign e_mflo    = e_special && (e_func == F_MFLO);
  assign d_md      = d_special && (d_func inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                                  F_MULT, F_MULTU, F_DIV, F_DIVU});

  // Register-number and shamt fields play no part in MD scheduling
  logic unused_instr_bits;
  assign unused_instr_bits = ^{E_Instr[25:6], D_Instr[25:6]};

  // Full 64-bit result of the op in E, computed at issue
  logic signed [2*WORD_W-1:0] sa64, sb64;
  logic        [2*WORD_W-1:0] ua64, ub64, res;
  logic        [WORD_W-1:0]   divisor, quot, rem;
  logic                       div_zero;

  always_comb begin
    res      = '0;
    quot     = '0;
    rem      = '0;
    div_zero = 1'b0;
    sa64     = {{WORD_W{E_RD1_forward[WORD_W-1]}}, E_RD1_forward};
    sb64     = {{WORD_W{E_RD2_forward[WORD_W-1]}}, E_RD2_forward};
    ua64     = {{WORD_W{1'b0}}, E_RD1_forward};
    ub64     = {{WORD_W{1'b0}}, E_RD2_forward};
    // Divisor forced non-zero so the divider never produces X; the commit is suppressed instead
    divisor  = (E_RD2_forward == '0) ? WORD_W'(1) : E_RD2_forward;
    case (e_func)
      F_MULT:  res = sa64 * sb64;
      F_MULTU: res = ua64 * ub64;
      F_DIV: begin
        div_zero = (E_RD2_forward == '0);
        // Most-negative / -1 overflows; architecturally it yields the dividend and zero remainder
        if (E_RD1_forward == 32'h8000_0000 && E_RD2_forward == 32'hFFFF_FFFF) begin
          quot = 32'h8000_0000;
          rem  = '0;
        end else begin
          quot = $signed(E_RD1_forward) / $signed(divisor);
          rem  = $signed(E_RD1_forward) % $signed(divisor);
        end
        res = {rem, quot};
      end
      F_DIVU: begin
        div_zero = (E_RD2_forward == '0);
        quot     = E_RD1_forward / divisor;
        rem      = E_RD1_forward % divisor;
        res      = {rem, quot};
      end
      default: res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (e_muldiv) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, stall request and mfhi/mflo read path
  always_comb begin
    Start    = (state_q == S_IDLE) && e_muldiv;
    Busy     = (state_q == S_RUN);
    MD_stall = d_md && (Start || Busy);
    E_MDout  = '0;
    if (e_mfhi)      E_MDout = hi_q;
    else if (e_mflo) E_MDout = lo_q;
  end

  // Countdown, pending result latch, HI/LO commit and mthi/mtlo writes
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_ok_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (e_muldiv) begin
            pend_q    <= res;
            pend_ok_q <= !div_zero;
            cnt_q     <= e_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          end else if (e_mthi) begin
            hi_q <= E_RD1_forward;
          end else if (e_mtlo) begin
            lo_q <= E_RD1_forward;
          end
        end
        S_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_q <= '0;
            if (pend_ok_q) begin
              hi_q <= pend_q[2*WORD_W-1:WORD_W];
              lo_q <= pend_q[WORD_W-1:0];
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: scoreboard bench for md_scheduler (HI/LO results, busy length, stalls).
module tb_md_scheduler;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADDU  = 6'h21;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_Instr, E_RD1_forward, E_RD2_forward, D_Instr;
  logic        Start, Busy, MD_stall;
  logic [31:0] HI, LO, E_MDout;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .E_Instr(E_Instr), .E_RD1_forward(E_RD1_forward), .E_RD2_forward(E_RD2_forward),
    .D_Instr(D_Instr),
    .Start(Start), .Busy(Busy), .MD_stall(MD_stall),
    .HI(HI), .LO(LO), .E_MDout(E_MDout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  hilo_t       sb_q[$];
  logic [31:0] m_hi, m_lo;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'b000000, 5'd4, 5'd5, 5'd0, 5'd0, f};
  endfunction

  // Reference {hi,lo} using 64-bit integer arithmetic
  function automatic hilo_t ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   input hilo_t cur);
    longint          sa, sb, sp, q, r;
    longint unsigned ua, ub, up, uq, ur;
    hilo_t           o;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    o  = cur;
    case (f)
      F_MULT:  begin sp = sa * sb; o = {sp[63:32], sp[31:0]}; end
      F_MULTU: begin up = ua * ub; o = {up[63:32], up[31:0]}; end
      F_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; o = {r[31:0], q[31:0]}; end
      F_DIVU:  if (b != 0) begin uq = ua / ub; ur = ua % ub; o = {ur[31:0], uq[31:0]}; end
      default: o = cur;
    endcase
    return o;
  endfunction

  function automatic bit is_md(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[5:0] inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                                     F_MULT, F_MULTU, F_DIV, F_DIVU});
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div in E with d_ins waiting in D; measure busy/stall length and check the commit
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] d_ins);
    int    busy_cnt;
    int    stall_cnt;
    int    n;
    hilo_t got;
    busy_cnt  = 0;
    stall_cnt = 0;
    n         = (f inside {F_MULT, F_MULTU}) ? int'(MC) : int'(DC);
    E_Instr = rtype(f); E_RD1_forward = a; E_RD2_forward = b; D_Instr = d_ins;
    {m_hi, m_lo} = ref_md(f, a, b, {m_hi, m_lo});
    sb_q.push_back({m_hi, m_lo});
    @(negedge clk);
    check({tag, "_start"}, 64'(Start), 64'd1);
    if (MD_stall) stall_cnt++;
    next_cycle();
    E_Instr = 32'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (Busy) busy_cnt++;
      if (MD_stall) stall_cnt++;
      if (!Busy) break;
      next_cycle();
    end
    check({tag, "_busy_len"}, 64'(busy_cnt), 64'(n));
    check({tag, "_stall_len"}, 64'(stall_cnt), is_md(d_ins) ? 64'(n + 1) : 64'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_hilo"}, {HI, LO}, {got.hi, got.lo});
    end
    next_cycle();
    D_Instr = 32'h0;
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] v);
    E_Instr = rtype(f); E_RD1_forward = v;
    next_cycle();
    E_Instr = 32'h0;
    if (f == F_MTHI) m_hi = v;
    else if (f == F_MTLO) m_lo = v;
  endtask

  initial begin
    logic [5:0]  rf;
    logic [31:0] ra, rb;
    m_hi = '0; m_lo = '0;
    reset = 1'b1; E_Instr = '0; E_RD1_forward = '0; E_RD2_forward = '0; D_Instr = rtype(F_MFLO);
    next_cycle();
    @(negedge clk);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    check("bubble_start", 64'(Start), 64'd0);
    check("rst_stall", 64'(MD_stall), 64'd0);

    // Reset and Start coincide: nothing launches
    next_cycle();
    E_Instr = rtype(F_MULT); E_RD1_forward = 32'd3; E_RD2_forward = 32'd4;
    next_cycle();
    reset = 1'b0; E_Instr = '0; D_Instr = '0;
    @(negedge clk);
    check("rst_start_busy", 64'(Busy), 64'd0);
    for (int i = 0; i < 8; i++) next_cycle();
    @(negedge clk);
    check("rst_start_hilo", {HI, LO}, 64'd0);
    next_cycle();

    run_op("mult", F_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0);
    run_op("multu_addu", F_MULTU, 32'hFFFF_FFFF, 32'd2, rtype(F_ADDU));
    run_op("div_mflo", F_DIV, 32'hFFFF_FFF9, 32'd2, rtype(F_MFLO));
    E_Instr = rtype(F_MFLO);
    @(negedge clk);
    check("mflo_val", 64'(E_MDout), 64'(m_lo));
    next_cycle();
    E_Instr = rtype(F_MFHI);
    @(negedge clk);
    check("mfhi_val", 64'(E_MDout), 64'(m_hi));
    next_cycle();
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // mthi then mfhi immediately, no stall
    E_Instr = rtype(F_MTHI); E_RD1_forward = 32'h1111; D_Instr = rtype(F_MFHI);
    @(negedge clk);
    check("mthi_nostall", 64'(MD_stall), 64'd0);
    next_cycle();
    m_hi = 32'h1111;
    E_Instr = rtype(F_MFHI); D_Instr = '0;
    @(negedge clk);
    check("mthi_mfhi", 64'(E_MDout), 64'h1111);
    next_cycle();
    move_to(F_MTLO, 32'h2222);
    run_op("divu_zero", F_DIVU, 32'd5, 32'd0, 32'h0);
    run_op("div_zero", F_DIV, 32'hFFFF_0000, 32'd0, rtype(F_MTHI));

    for (int i = 0; i < 6; i++) begin
      rf = F_MULT + 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      run_op($sformatf("rnd%0d", i), rf, ra, rb, ($urandom_range(0, 1) == 1) ? rtype(F_MFHI) : 32'h0);
    end

    // Reset during the third busy cycle of a div
    move_to(F_MTHI, 32'hABCD);
    E_Instr = rtype(F_DIV); E_RD1_forward = 32'd100; E_RD2_forward = 32'd7;
    next_cycle();
    E_Instr = '0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_hilo", {HI, LO}, 64'd0);
    for (int i = 0; i < 15; i++) next_cycle();
    @(negedge clk);
    check("rst_mid_nocommit", {HI, LO}, {m_hi, m_lo});
    check("rst_mid_idle", 64'(Busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multiply/divide unit scheduler for the 5-stage pipeline: owns the HI/LO registers, sequences the multi-cycle mult/multu/div/divu operations issued from the E stage, and raises the D-stage stall request for any MD-class instruction that would collide with an operation still in flight. It sits beside the E-stage ALU, takes its operands after E-stage forwarding, and feeds mfhi/mflo results into the E-stage result mux. The hazard/stall logic ORs MD_stall into the pipeline stall.

## Interface

- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- E_Instr  in  32  instruction currently in E; a bubble is 0x00000000
- E_RD1_forward  in  32  rs operand after E-stage forwarding
- E_RD2_forward  in  32  rt operand after E-stage forwarding
- D_Instr  in  32  instruction currently in D
- Start  out  1  combinational; high when E_Instr is mult/multu/div/divu and Busy=0
- Busy  out  1  registered; high while an operation is in flight
- MD_stall  out  1  combinational D-stage stall request
- HI  out  32  HI register
- LO  out  32  LO register
- E_MDout  out  32  mfhi→HI, mflo→LO, otherwise 0

## Operation

- Decode uses op=31:26 and func=5:0 with op=000000.
  - mult 011000, multu 011001, div 011010, divu 011011
  - mfhi 010000, mflo 010010, mthi 010001, mtlo 010011
- MD-class instructions are those 8 functions.
- The unit has two states, IDLE (Busy=0) and RUN (Busy=1). A 4-bit counter cnt tracks progress.
- IDLE + Start:
  - Compute the 64-bit result from E_RD1_forward/E_RD2_forward and latch it into pending {hi,lo}.
  - Load cnt with MULT_CYCLES or DIV_CYCLES and go to RUN.
- RUN: cnt decrements every cycle. On the edge where cnt==1, commit pending to HI/LO, set cnt=0 and return to IDLE.
- mult: signed 32×32→64, HI=upper word, LO=lower word. multu: unsigned.
- div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (div or divu with rt=0): the operation still occupies DIV_CYCLES, but the commit is suppressed, so HI and LO are unchanged.
- mthi/mtlo in E with Busy=0 write rs into HI/LO at the end of that cycle. With Busy=1 they are ignored (MD_stall makes this unreachable).
- mfhi/mflo read HI/LO combinationally through E_MDout. They never observe the pending value.
- A mult/div in E while Busy=1 is ignored (unreachable in correct operation).
- MD_stall = D_Instr is MD-class AND (Start OR Busy).

## Timing

- Reset values: Busy=0, cnt=0, HI=0, LO=0, pending=0. Start, MD_stall and E_MDout follow their inputs combinationally.
- Reset mid-operation: the pending result is discarded, HI/LO are cleared, and Busy=0 on the next cycle.
- Sequence for a mult/div that is in E in cycle T with Start=1:
  - Busy is high in cycles T+1..T+N, where N=MULT_CYCLES or DIV_CYCLES.
  - HI/LO take the new value at the end of T+N.
  - Busy=0 in T+N+1.
- An MD instruction in D during cycle T stalls for cycles T..T+N (N+1 cycles) and enters E in T+N+1. There it sees the committed HI/LO.
- A non-MD instruction in D never stalls on this block.
- Back-to-back mult followed by mult: the second stalls in D until Busy falls, then issues with Start in T+N+1.
- mthi in E at cycle T followed by mfhi in E at T+1: mfhi returns the new value with no stall.
- If reset and Start coincide, reset wins: no operation is launched.

## Test plan

- **mult:** rs=0xFFFFFFFD (−3), rt=5 with MULT_CYCLES=5 → Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **multu:** rs=0xFFFFFFFF, rt=2 → HI=0x00000001, LO=0xFFFFFFFE.
- **div then mflo:** div rs=0xFFFFFFF9 (−7), rt=2 followed immediately by mflo in D → MD_stall high for 11 cycles. mflo then returns LO=0xFFFFFFFD, and HI=0xFFFFFFFF.
- **divu by zero:** preload HI=0x1111, LO=0x2222 via mthi/mtlo, then divu with rt=0 → Busy high 10 cycles; HI/LO remain 0x1111/0x2222 afterwards.
- **Reset mid-operation:** assert reset during cycle 3 of a div → Busy=0, HI=LO=0 in the next cycle, and no later commit occurs.
- **No false stall:** an addu in D while Busy=1 → MD_stall=0. Bubbles (0x00000000) in E never raise Start.
